// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its lane aligner.
package lsu_pkg;

  localparam int MEM_BYTES = 64;
  localparam int MAX_BASE  = MEM_BYTES - 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Reserved size reports 0 bytes; callers flag it as a fault separately.
  function automatic logic [2:0] size_bytes(size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath-side request/response bundle of the load/store unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_done;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_done, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_done, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction for loads and byte-lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] sdata
);

  logic [31:0] aligned;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [4:0]  shamt;

  always_comb begin
    shamt   = {lane, 3'b000};
    // Lane 0 sits in bits [31:24]; shifting it to the top makes extraction size-only.
    aligned = word << shamt;
    ldata   = '0;
    mask    = '0;
    ins     = '0;
    case (size)
      SZ_BYTE: begin
        ldata = {{24{sgn & aligned[31]}}, aligned[31:24]};
        mask  = 32'hFF00_0000 >> shamt;
        ins   = {wdata[7:0], 24'h00_0000} >> shamt;
      end
      SZ_HALF: begin
        ldata = {{16{sgn & aligned[31]}}, aligned[31:16]};
        mask  = 32'hFFFF_0000 >> shamt;
        ins   = {wdata[15:0], 16'h0000} >> shamt;
      end
      SZ_WORD: begin
        ldata = aligned;
        mask  = 32'hFFFF_FFFF >> shamt;
        ins   = wdata >> shamt;
      end
      default: begin
        ldata = '0;
      end
    endcase
    sdata = (word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses to a 4-byte-wide big-endian memory,
// sub-word stores by read-modify-write, out-of-range requests reported as faults.
//
// state | meaning
// IDLE  | ready for a request; fault check and window base computed on accept
// READ  | window word on mem_rdata; load result or merged store word captured
// WRITE | merged word written back at mem_addr (suppressed while rst_n is low)
// RESP  | one-cycle rsp_done with rsp_fault / rsp_rdata valid
module mem_access_unit #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import lsu_pkg::*;

  localparam logic [ADDR_W-1:0] BASE_MAX  = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W:0]   END_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  state_e            state, nxt;
  logic              accept;
  size_e             size_now;
  logic [ADDR_W:0]   end_now;
  logic              fault_now;
  logic [ADDR_W-1:0] base_now;
  logic [1:0]        lane_now;

  logic              store_q;
  size_e             size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fault_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_val;

  assign size_now  = size_e'(bus.req_size);
  // One extra bit so addr + n never wraps below MEM_BYTES.
  assign end_now   = {1'b0, bus.req_addr} + {{(ADDR_W - 2){1'b0}}, size_bytes(size_now)};
  assign fault_now = (size_now == SZ_RSVD) || (end_now > END_LIMIT);
  assign base_now  = (bus.req_addr > BASE_MAX) ? BASE_MAX : bus.req_addr;
  assign lane_now  = 2'(bus.req_addr - base_now);
  assign accept    = bus.req_valid && bus.req_ready;

  lsu_lane_align u_align (
    .word  (mem_rdata),
    .lane  (lane_q),
    .size  (size_q),
    .sgn   (sgn_q),
    .wdata (wdata_q),
    .ldata (load_val),
    .sdata (merge_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      store_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      lane_q      <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        store_q <= bus.req_store;
        size_q  <= size_now;
        sgn_q   <= bus.req_signed;
        wdata_q <= bus.req_wdata;
        fault_q <= fault_now;
        lane_q  <= lane_now;
        if (fault_now) rdata_q <= '0;
        else           mem_addr_q <= base_now;
      end
      if (state == READ) begin
        if (store_q) mem_wdata_q <= merge_val;
        else         rdata_q     <= load_val;
      end
      // Cleared here rather than in READ so the previous load result holds until RESP.
      if (state == WRITE) rdata_q <= '0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) nxt = fault_now ? RESP : READ;
      READ:    nxt = store_q ? WRITE : RESP;
      WRITE:   nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_done  = (state == RESP);
  assign bus.rsp_fault = (state == RESP) && fault_q;
  assign bus.rsp_rdata = rdata_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wen       = (state == WRITE) && rst_n;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 64-byte big-endian memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  logic [5:0]  mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  mem [64];

  mem_access_unit #(.MEM_BYTES(64), .ADDR_W(6), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always_comb begin
    if (mem_addr <= 6'd60)
      mem_rdata = {mem[mem_addr], mem[mem_addr + 6'd1], mem[mem_addr + 6'd2], mem[mem_addr + 6'd3]};
    else
      mem_rdata = 32'hFFFF_FFFF;
  end

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr]        <= mem_wdata[31:24];
      mem[mem_addr + 6'd1] <= mem_wdata[23:16];
      mem[mem_addr + 6'd2] <= mem_wdata[15:8];
      mem[mem_addr + 6'd3] <= mem_wdata[7:0];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [5:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_f, input int exp_lat,
                        input logic [5:0] exp_ma, input logic [31:0] exp_wd);
    exp_t        e;
    int          k;
    int          wens;
    logic [5:0]  wa;
    logic [31:0] wdv;
    logic [5:0]  ra;
    wa  = '0;
    wdv = '0;
    @(negedge clk);
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    e.rdata = exp_rd;
    e.fault = exp_f;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k    = 1;
    wens = 0;
    ra   = mem_addr;
    while (!bus.rsp_done && k < 10) begin
      if (mem_wen) begin
        wens++;
        wa  = mem_addr;
        wdv = mem_wdata;
      end
      @(negedge clk);
      k++;
    end
    chk({tag, "/done"}, 32'(bus.rsp_done), 32'd1);
    e = sb.pop_front();
    chk({tag, "/rdata"}, bus.rsp_rdata, e.rdata);
    chk({tag, "/fault"}, 32'(bus.rsp_fault), 32'(e.fault));
    chk({tag, "/latency"}, 32'(k), 32'(exp_lat));
    chk({tag, "/wen_count"}, 32'(wens), (st && !exp_f) ? 32'd1 : 32'd0);
    if (!exp_f) chk({tag, "/mem_addr"}, 32'(ra), 32'(exp_ma));
    if (wens == 1) begin
      chk({tag, "/wr_addr"}, 32'(wa), 32'(exp_ma));
      chk({tag, "/wr_data"}, wdv, exp_wd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0]  = 8'h99; mem[1]  = 8'h36; mem[2]  = 8'h8F; mem[3]  = 8'h7E; mem[4] = 8'hD9;
    mem[60] = 8'h42; mem[61] = 8'h18; mem[62] = 8'h88; mem[63] = 8'h04;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/rsp_done", 32'(bus.rsp_done), 32'd0);
    chk("rst/rsp_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst/mem_addr", 32'(mem_addr), 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    chk("rst/mem_wen", 32'(mem_wen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/req_ready", 32'(bus.req_ready), 32'd1);

    // tag, store, size, signed, addr, wdata, exp rdata, exp fault, latency, exp mem_addr, exp wdata
    access("ld_w0",    1'b0, 2'd2, 1'b0, 6'd0,  32'h0,        32'h99368F7E, 1'b0, 2, 6'd0,  32'h0);
    access("ld_bs0",   1'b0, 2'd0, 1'b1, 6'd0,  32'h0,        32'hFFFFFF99, 1'b0, 2, 6'd0,  32'h0);
    access("ld_bu0",   1'b0, 2'd0, 1'b0, 6'd0,  32'h0,        32'h00000099, 1'b0, 2, 6'd0,  32'h0);
    access("ld_hs2",   1'b0, 2'd1, 1'b1, 6'd2,  32'h0,        32'hFFFF8F7E, 1'b0, 2, 6'd2,  32'h0);
    access("ld_b63",   1'b0, 2'd0, 1'b0, 6'd63, 32'h0,        32'h00000004, 1'b0, 2, 6'd60, 32'h0);
    access("st_b63",   1'b1, 2'd0, 1'b0, 6'd63, 32'h000000AB, 32'h00000000, 1'b0, 3, 6'd60, 32'h421888AB);
    access("ld_bs63",  1'b0, 2'd0, 1'b1, 6'd63, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 6'd60, 32'h0);
    access("ld_hu62",  1'b0, 2'd1, 1'b0, 6'd62, 32'h0,        32'h000088AB, 1'b0, 2, 6'd60, 32'h0);
    access("ld_w60",   1'b0, 2'd2, 1'b0, 6'd60, 32'h0,        32'h421888AB, 1'b0, 2, 6'd60, 32'h0);
    access("st_h1",    1'b1, 2'd1, 1'b0, 6'd1,  32'h0000BEEF, 32'h00000000, 1'b0, 3, 6'd1,  32'hBEEF7ED9);
    access("ld_w0b",   1'b0, 2'd2, 1'b0, 6'd0,  32'h0,        32'h99BEEF7E, 1'b0, 2, 6'd0,  32'h0);
    access("st_w8",    1'b1, 2'd2, 1'b0, 6'd8,  32'h12345678, 32'h00000000, 1'b0, 3, 6'd8,  32'h12345678);
    access("ld_w8",    1'b0, 2'd2, 1'b0, 6'd8,  32'h0,        32'h12345678, 1'b0, 2, 6'd8,  32'h0);
    access("flt_w61",  1'b0, 2'd2, 1'b0, 6'd61, 32'h0,        32'h00000000, 1'b1, 1, 6'd0,  32'h0);
    access("flt_h63",  1'b1, 2'd1, 1'b0, 6'd63, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 6'd0,  32'h0);
    access("flt_rsvd", 1'b0, 2'd3, 1'b0, 6'd0,  32'h0,        32'h00000000, 1'b1, 1, 6'd0,  32'h0);

    // Reset during the WRITE cycle of a byte store must drop the write.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 6'd0;
    bus.req_wdata  = 32'h00000055;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstw/wen_before", 32'(mem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw/wen_gated", 32'(mem_wen), 32'd0);
    @(negedge clk);
    chk("rstw/mem0", 32'(mem[0]), 32'h00000099);
    chk("rstw/req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw/rsp_done", 32'(bus.rsp_done), 32'd0);
    rst_n = 1'b1;
    access("ld_w0c",   1'b0, 2'd2, 1'b0, 6'd0,  32'h0,        32'h99BEEF7E, 1'b0, 2, 6'd0,  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
